// File: rtl/decode_pipe_pkg.sv
// Shared decode types for the decode pipeline: opcode/funct enums, ALU and
// compare operation codes, operand/writeback selects, the decoded-field
// struct and the immediate generator.
package decode;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LUI    = 7'b0110111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'd0,
    F3_SLL     = 3'd1,
    F3_SLT     = 3'd2,
    F3_SLTU    = 3'd3,
    F3_XOR     = 3'd4,
    F3_SRL_SRA = 3'd5,
    F3_OR      = 3'd6,
    F3_AND     = 3'd7
  } funct3_alu_e;

  typedef enum logic [6:0] {
    F7_BASE   = 7'h00,
    F7_MULDIV = 7'h01,
    F7_ALT    = 7'h20
  } funct7_e;

  // Base ALU codes first, M-extension codes appended at 11..18
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_COPY_B = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  // Branch compare codes share the branch funct3 encoding
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd4,
    CMP_GE  = 3'd5,
    CMP_LTU = 3'd6,
    CMP_GEU = 3'd7
  } cmp_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef enum logic [0:0] { SRC1_RS1, SRC1_PC  } src1_sel_e;
  typedef enum logic [0:0] { SRC2_RS2, SRC2_IMM } src2_sel_e;
  typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_PC4 } wb_sel_e;
  typedef enum logic [0:0] { JBASE_PC, JBASE_RS1 } jump_base_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_e    alu_op;
    cmp_op_e    cmp_op;
    src1_sel_e  src1_sel;
    src2_sel_e  src2_sel;
    wb_sel_e    wb_sel;
    jump_base_e jump_base_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       is_branch;
    logic       is_jump;
    logic       illegal;
    logic [2:0] mem_funct3;
  } decoded_t;

  // 32-bit sign-extended immediate; callers widen it to XLEN
  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_sel_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_pipe_comb.sv
// Pure combinational RV32I instruction decoder.
// Build option: DECODE_M_EXT_EN enables MUL/DIV/REM decoding on OP with
// funct7=0000001; without it those encodings are reported as illegal.
module decode_comb
  import decode::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm,
  output logic            uses_rs1,
  output logic            uses_rs2
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_sel_e   imm_sel;
  logic       bad;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm    = XLEN'($signed(gen_imm(inst, imm_sel)));

  // Map opcode/funct fields to control fields; reserved encodings set bad
  always_comb begin
    dec          = '0;
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    imm_sel      = IMM_NONE;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    bad          = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        imm_sel        = IMM_I;
        uses_rs1       = 1'b1;
        dec.mem_read   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.src2_sel   = SRC2_IMM;
        dec.wb_sel     = WB_MEM;
        dec.mem_funct3 = f3;
        bad            = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        imm_sel        = IMM_S;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        dec.mem_write  = 1'b1;
        dec.src2_sel   = SRC2_IMM;
        dec.rd         = '0;
        dec.mem_funct3 = f3;
        bad            = (f3 > 3'd2);
      end
      OPC_OP_IMM: begin
        imm_sel       = IMM_I;
        uses_rs1      = 1'b1;
        dec.reg_write = 1'b1;
        dec.src2_sel  = SRC2_IMM;
        case (f3)
          F3_ADD_SUB: dec.alu_op = ALU_ADD;
          F3_SLT:     dec.alu_op = ALU_SLT;
          F3_SLTU:    dec.alu_op = ALU_SLTU;
          F3_XOR:     dec.alu_op = ALU_XOR;
          F3_OR:      dec.alu_op = ALU_OR;
          F3_AND:     dec.alu_op = ALU_AND;
          F3_SLL: begin
            dec.alu_op = ALU_SLL;
            bad        = (f7 != F7_BASE);
          end
          default: begin
            if (f7 == F7_BASE)     dec.alu_op = ALU_SRL;
            else if (f7 == F7_ALT) dec.alu_op = ALU_SRA;
            else                   bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.reg_write = 1'b1;
        case (f7)
          F7_BASE: begin
            case (f3)
              F3_ADD_SUB: dec.alu_op = ALU_ADD;
              F3_SLL:     dec.alu_op = ALU_SLL;
              F3_SLT:     dec.alu_op = ALU_SLT;
              F3_SLTU:    dec.alu_op = ALU_SLTU;
              F3_XOR:     dec.alu_op = ALU_XOR;
              F3_SRL_SRA: dec.alu_op = ALU_SRL;
              F3_OR:      dec.alu_op = ALU_OR;
              default:    dec.alu_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (f3 == F3_ADD_SUB)      dec.alu_op = ALU_SUB;
            else if (f3 == F3_SRL_SRA) dec.alu_op = ALU_SRA;
            else                       bad = 1'b1;
          end
          F7_MULDIV: begin
`ifdef DECODE_M_EXT_EN
            dec.alu_op = alu_op_e'({2'b00, f3} + 5'd11);
`else
            bad = 1'b1;
`endif
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        imm_sel       = IMM_B;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.is_branch = 1'b1;
        dec.rd        = '0;
        if (f3[2:1] == 2'b01) bad = 1'b1;
        else                  dec.cmp_op = cmp_op_e'(f3);
      end
      OPC_JAL: begin
        imm_sel       = IMM_J;
        dec.is_jump   = 1'b1;
        dec.reg_write = 1'b1;
        dec.src1_sel  = SRC1_PC;
        dec.src2_sel  = SRC2_IMM;
        dec.wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        imm_sel           = IMM_I;
        uses_rs1          = 1'b1;
        dec.is_jump       = 1'b1;
        dec.reg_write     = 1'b1;
        dec.src2_sel      = SRC2_IMM;
        dec.wb_sel        = WB_PC4;
        dec.jump_base_sel = JBASE_RS1;
        bad               = (f3 != 3'd0);
      end
      OPC_AUIPC: begin
        imm_sel       = IMM_U;
        dec.reg_write = 1'b1;
        dec.src1_sel  = SRC1_PC;
        dec.src2_sel  = SRC2_IMM;
      end
      OPC_LUI: begin
        imm_sel       = IMM_U;
        dec.reg_write = 1'b1;
        dec.src2_sel  = SRC2_IMM;
        dec.alu_op    = ALU_COPY_B;
      end
      default: bad = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) bad = 1'b1;
    // Illegal instructions still flow downstream but must not touch state
    if (bad) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode pipeline stage: one registered output stage with valid/ready
// handshake, load-use hazard stall, flush and a saturating stall counter.
// Build option: DECODE_M_EXT_EN (passed through to decode_comb).
module decode_pipe
  import decode::*;
#(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [XLEN-1:0]        out_imm,
  output logic [4:0]             out_alu_op,
  output logic [2:0]             out_cmp_op,
  output logic                   out_src1_sel,
  output logic                   out_src2_sel,
  output logic [1:0]             out_wb_sel,
  output logic                   out_jump_base_sel,
  output logic                   out_reg_write,
  output logic                   out_mem_read,
  output logic                   out_mem_write,
  output logic                   out_is_branch,
  output logic                   out_is_jump,
  output logic                   out_illegal,
  output logic [2:0]             out_mem_funct3,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  decoded_t        dec_d, dec_q;
  logic [XLEN-1:0] imm_d;
  logic            uses_rs1, uses_rs2;
  logic            hazard;
  logic            transfer;

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .inst     (in_inst),
    .dec      (dec_d),
    .imm      (imm_d),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign hazard = out_valid && dec_q.mem_read && (dec_q.rd != 5'd0) &&
                  ((uses_rs1 && (in_inst[19:15] == dec_q.rd)) ||
                   (uses_rs2 && (in_inst[24:20] == dec_q.rd)));

  assign in_ready = rst_n && (!out_valid || out_ready) && !hazard && !flush;
  assign transfer = in_valid && in_ready;

  // Output stage: flush squashes, accepted input loads, consumed output drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dec_q     <= '0;
      out_pc    <= '0;
      out_imm   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      dec_q     <= dec_d;
      out_pc    <= in_pc;
      out_imm   <= imm_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count load-use stall cycles, sticking at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign out_rd            = dec_q.rd;
  assign out_rs1           = dec_q.rs1;
  assign out_rs2           = dec_q.rs2;
  assign out_alu_op        = dec_q.alu_op;
  assign out_cmp_op        = dec_q.cmp_op;
  assign out_src1_sel      = dec_q.src1_sel;
  assign out_src2_sel      = dec_q.src2_sel;
  assign out_wb_sel        = dec_q.wb_sel;
  assign out_jump_base_sel = dec_q.jump_base_sel;
  assign out_reg_write     = dec_q.reg_write;
  assign out_mem_read      = dec_q.mem_read;
  assign out_mem_write     = dec_q.mem_write;
  assign out_is_branch     = dec_q.is_branch;
  assign out_is_jump       = dec_q.is_jump;
  assign out_illegal       = dec_q.illegal;
  assign out_mem_funct3    = dec_q.mem_funct3;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed testbench for decode_pipe. Uses a 2-bit stall counter so the
// saturation boundary is reachable in a few hazards.
module tb_decode_pipe;

  localparam int XLEN = 32;
  localparam int SCW  = 2;

  localparam logic [31:0] ADDI_X1   = 32'hFFB00093;
  localparam logic [31:0] LW_X5     = 32'h00012283;
  localparam logic [31:0] ADD_X6_X5 = 32'h00728333;
  localparam logic [31:0] LW_X0     = 32'h00012003;
  localparam logic [31:0] ADD_X6_X0 = 32'h00700333;
  localparam logic [31:0] BEQ_8     = 32'h00208463;
  localparam logic [31:0] SW_X5     = 32'h00512223;
  localparam logic [31:0] JAL_M4    = 32'hFFDFF0EF;
  localparam logic [31:0] LUI_X7    = 32'h123453B7;
  localparam logic [31:0] MUL_X3    = 32'h022081B3;
  localparam logic [31:0] BAD_LOW   = 32'hFFB00090;
  localparam logic [31:0] BAD_OPC   = 32'h0000007F;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [4:0]      out_rd, out_rs1, out_rs2, out_alu_op;
  logic [2:0]      out_cmp_op, out_mem_funct3;
  logic            out_src1_sel, out_src2_sel, out_jump_base_sel;
  logic [1:0]      out_wb_sel;
  logic            out_reg_write, out_mem_read, out_mem_write;
  logic            out_is_branch, out_is_jump, out_illegal;
  logic [SCW-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(XLEN), .STALL_CNT_W(SCW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_inst           (in_inst),
    .in_pc             (in_pc),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_rd            (out_rd),
    .out_rs1           (out_rs1),
    .out_rs2           (out_rs2),
    .out_imm           (out_imm),
    .out_alu_op        (out_alu_op),
    .out_cmp_op        (out_cmp_op),
    .out_src1_sel      (out_src1_sel),
    .out_src2_sel      (out_src2_sel),
    .out_wb_sel        (out_wb_sel),
    .out_jump_base_sel (out_jump_base_sel),
    .out_reg_write     (out_reg_write),
    .out_mem_read      (out_mem_read),
    .out_mem_write     (out_mem_write),
    .out_is_branch     (out_is_branch),
    .out_is_jump       (out_is_jump),
    .out_illegal       (out_illegal),
    .out_mem_funct3    (out_mem_funct3),
    .stall_cnt         (stall_cnt)
  );

  // Advance one clock and sample just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs, then let combinational outputs settle
  task automatic applyStimulus(input logic v, input logic [31:0] inst,
                               input logic [XLEN-1:0] pc, input logic rdy,
                               input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  // Count one comparison and report it on mismatch
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [SCW-1:0] exp_cnt;

    // Reset while an instruction is offered
    rst_n = 1'b0;
    applyStimulus(1'b1, ADDI_X1, 32'h100, 1'b1, 1'b0);
    checkOutput("rst_in_ready", in_ready, 0);
    step();
    step();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_alu_op", out_alu_op, 0);
    checkOutput("rst_rd", out_rd, 0);
    checkOutput("rst_imm", out_imm, 0);
    checkOutput("rst_illegal", out_illegal, 0);

    // ADDI x1,x0,-5
    rst_n = 1'b1;
    #1;
    checkOutput("addi_in_ready", in_ready, 1);
    step();
    checkOutput("addi_valid", out_valid, 1);
    checkOutput("addi_rd", out_rd, 1);
    checkOutput("addi_imm", out_imm, 32'hFFFFFFFB);
    checkOutput("addi_alu", out_alu_op, 0);
    checkOutput("addi_src2", out_src2_sel, 1);
    checkOutput("addi_regw", out_reg_write, 1);
    checkOutput("addi_pc", out_pc, 32'h100);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("drain_valid", out_valid, 0);

    // Load-use hazard: LW x5 then ADD x6,x5,x7
    applyStimulus(1'b1, LW_X5, 32'h104, 1'b1, 1'b0);
    step();
    checkOutput("lw_mem_read", out_mem_read, 1);
    checkOutput("lw_wb_sel", out_wb_sel, 1);
    checkOutput("lw_funct3", out_mem_funct3, 2);
    applyStimulus(1'b1, ADD_X6_X5, 32'h108, 1'b1, 1'b0);
    checkOutput("haz_in_ready", in_ready, 0);
    step();
    checkOutput("haz_bubble", out_valid, 0);
    checkOutput("haz_cnt", stall_cnt, 1);
    checkOutput("haz_release", in_ready, 1);
    step();
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_rd", out_rd, 6);
    checkOutput("add_rs1", out_rs1, 5);
    checkOutput("add_rs2", out_rs2, 7);
    checkOutput("add_src2", out_src2_sel, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Load to x0 never stalls
    applyStimulus(1'b1, LW_X0, 32'h10C, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, ADD_X6_X0, 32'h110, 1'b1, 1'b0);
    checkOutput("x0_in_ready", in_ready, 1);
    step();
    checkOutput("x0_valid", out_valid, 1);
    checkOutput("x0_rd", out_rd, 6);
    checkOutput("x0_cnt", stall_cnt, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Repeated hazards drive the 2-bit counter into saturation
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, LW_X5, 32'h120, 1'b1, 1'b0);
      step();
      applyStimulus(1'b1, ADD_X6_X5, 32'h124, 1'b1, 1'b0);
      step();
      exp_cnt = (k + 2 > 3) ? 2'd3 : SCW'(k + 2);
      checkOutput($sformatf("sat_cnt_%0d", k), stall_cnt, exp_cnt);
      checkOutput($sformatf("sat_bubble_%0d", k), out_valid, 0);
      step();
      checkOutput($sformatf("sat_add_%0d", k), out_valid, 1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // BEQ held under back-pressure for three cycles
    applyStimulus(1'b1, BEQ_8, 32'h200, 1'b1, 1'b0);
    step();
    checkOutput("beq_branch", out_is_branch, 1);
    applyStimulus(1'b1, ADDI_X1, 32'h204, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("hold_in_ready_%0d", i), in_ready, 0);
      step();
      checkOutput($sformatf("hold_valid_%0d", i), out_valid, 1);
      checkOutput($sformatf("hold_imm_%0d", i), out_imm, 8);
      checkOutput($sformatf("hold_rd_%0d", i), out_rd, 0);
      checkOutput($sformatf("hold_rs2_%0d", i), out_rs2, 2);
      checkOutput($sformatf("hold_regw_%0d", i), out_reg_write, 0);
      checkOutput($sformatf("hold_pc_%0d", i), out_pc, 32'h200);
      checkOutput($sformatf("hold_cmp_%0d", i), out_cmp_op, 0);
    end
    applyStimulus(1'b1, ADDI_X1, 32'h204, 1'b1, 1'b0);
    checkOutput("release_in_ready", in_ready, 1);
    step();
    checkOutput("release_rd", out_rd, 1);
    checkOutput("release_pc", out_pc, 32'h204);

    // Flush beats a simultaneous incoming instruction
    applyStimulus(1'b1, SW_X5, 32'h208, 1'b0, 1'b1);
    checkOutput("flush_in_ready", in_ready, 0);
    step();
    checkOutput("flush_valid", out_valid, 0);

    // Store: rd forced to zero, S-immediate
    applyStimulus(1'b1, SW_X5, 32'h208, 1'b1, 1'b0);
    step();
    checkOutput("sw_valid", out_valid, 1);
    checkOutput("sw_rd", out_rd, 0);
    checkOutput("sw_memw", out_mem_write, 1);
    checkOutput("sw_regw", out_reg_write, 0);
    checkOutput("sw_imm", out_imm, 4);
    checkOutput("sw_funct3", out_mem_funct3, 2);

    // JAL with negative J-immediate
    applyStimulus(1'b1, JAL_M4, 32'h20C, 1'b1, 1'b0);
    step();
    checkOutput("jal_imm", out_imm, 32'hFFFFFFFC);
    checkOutput("jal_jump", out_is_jump, 1);
    checkOutput("jal_wb", out_wb_sel, 2);
    checkOutput("jal_src1", out_src1_sel, 1);
    checkOutput("jal_jbase", out_jump_base_sel, 0);
    checkOutput("jal_rd", out_rd, 1);

    // LUI
    applyStimulus(1'b1, LUI_X7, 32'h210, 1'b1, 1'b0);
    step();
    checkOutput("lui_imm", out_imm, 32'h12345000);
    checkOutput("lui_alu", out_alu_op, 10);
    checkOutput("lui_rd", out_rd, 7);

    // MUL depends on the M-extension build option
    applyStimulus(1'b1, MUL_X3, 32'h214, 1'b1, 1'b0);
    step();
    checkOutput("mul_valid", out_valid, 1);
`ifdef DECODE_M_EXT_EN
    checkOutput("mul_illegal", out_illegal, 0);
    checkOutput("mul_alu", out_alu_op, 11);
    checkOutput("mul_regw", out_reg_write, 1);
`else
    checkOutput("mul_illegal", out_illegal, 1);
    checkOutput("mul_regw", out_reg_write, 0);
`endif

    // Illegal encodings still pass downstream
    applyStimulus(1'b1, BAD_LOW, 32'h218, 1'b1, 1'b0);
    step();
    checkOutput("low_valid", out_valid, 1);
    checkOutput("low_illegal", out_illegal, 1);
    checkOutput("low_regw", out_reg_write, 0);
    applyStimulus(1'b1, BAD_OPC, 32'h21C, 1'b0, 1'b0);
    step();
    checkOutput("opc_illegal", out_illegal, 1);
    checkOutput("opc_memr", out_mem_read, 0);
    checkOutput("opc_memw", out_mem_write, 0);

    // Reset while an instruction is held
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 0);
    step();
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_cnt", stall_cnt, 0);
    checkOutput("midrst_illegal", out_illegal, 0);
    checkOutput("midrst_pc", out_pc, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("post_rst_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of the hazard-stall counter.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1  fetch-side handshake.
REQ-006 SHALL have ports in_inst input 32, in_pc input XLEN  instruction and its address.
REQ-007 SHALL have port flush  input  1  squash the held instruction (redirect from execute).
REQ-008 SHALL have ports out_valid output 1, out_ready input 1  execute-side handshake.
REQ-009 SHALL have outputs out_pc XLEN, out_rd/out_rs1/out_rs2 5 each, out_imm XLEN (sign-extended).
REQ-010 SHALL have outputs out_alu_op 5 (alu_op_e), out_cmp_op 3, out_src1_sel 1, out_src2_sel 1, out_wb_sel 2, out_jump_base_sel 1.
REQ-011 SHALL have outputs out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump, out_illegal (1 each), out_mem_funct3 3.
REQ-012 SHALL have output stall_cnt  STALL_CNT_W  count of load-use stall cycles.

Function
REQ-013 SHALL decode RV32I opcodes LOAD, STORE, OP-IMM, OP, BRANCH, JAL, JALR, AUIPC, LUI; I/S/B/U/J immediates sign-extended to XLEN.
REQ-014 SHALL register all decoded fields in one output stage: transfer in (in_valid&&in_ready) at edge N appears with out_valid=1 after edge N.
REQ-015 SHALL hold every out_* stable while out_valid=1 and out_ready=0.
REQ-016 SHALL drive in_ready = (!out_valid || out_ready) && !hazard && !flush, combinationally.
REQ-017 SHALL define hazard = out_valid && out_mem_read && out_rd!=0 && ((uses_rs1 && in rs1==out_rd) || (uses_rs2 && in rs2==out_rd)), uses_rsX from incoming opcode (LUI/AUIPC/JAL use none; OP-IMM/LOAD/JALR use rs1 only).
REQ-018 SHALL clear out_valid on an edge where out_ready=1 and no transfer in, giving exactly one bubble after a hazard.
REQ-019 SHALL, on flush=1, clear out_valid at the next edge regardless of out_ready; flush wins over simultaneous in_valid.
REQ-020 SHALL set out_illegal=1 with out_reg_write/out_mem_read/out_mem_write=0 for unknown opcode, reserved funct3/funct7, or in_inst[1:0]!=2'b11; instruction still passes downstream.
REQ-021 SHALL increment stall_cnt on each edge with in_valid && hazard && !flush, saturating at all-ones.
REQ-022 SHALL force out_rd=0 and out_reg_write=0 for STORE and BRANCH.

Reset
REQ-023 SHALL, with rst_n=0 at an edge, set out_valid=0, stall_cnt=0, all other out_* registers 0 (out_alu_op=ADD, out_illegal=0).
REQ-024 SHALL discard any held instruction on reset mid-handshake; in_ready=0 while rst_n=0.

Configuration
REQ-025 SHALL, with DECODE_M_EXT_EN defined, decode OP with funct7=0000001 as MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (alu_op_e codes 11-18).
REQ-026 SHALL, without DECODE_M_EXT_EN, flag funct7=0000001 on OP as out_illegal=1.

Structure
REQ-027 SHALL take opcode_e, funct3/funct7 enums, imm_sel_e, cmp_op_e, select enums from package decode; alu_op_e SHALL widen there to 5 bits with M-extension codes appended.
REQ-028 SHALL place pure combinational decoding in sub-module decode_comb; decode_pipe holds registers, handshake, hazard and counter.

Verification
REQ-029 ADDI x1,x0,-5 (0xFFB00093), out_ready=1 -> one cycle later out_valid=1, out_rd=1, out_imm=0xFFFFFFFB, out_alu_op=ADD, out_src2_sel=imm.
REQ-030 LW x5,0(x2) then ADD x6,x5,x7 back-to-back -> in_ready=0 one cycle, one bubble on out_valid, stall_cnt=1.
REQ-031 LW x0,0(x2) then ADD x6,x0,x7 -> no stall, stall_cnt stays 0.
REQ-032 out_ready=0 for 3 cycles with BEQ held -> all out_* unchanged, in_ready=0; release -> transfer next edge.
REQ-033 flush=1 with valid held and in_valid=1 -> out_valid=0 next edge, incoming not accepted.
REQ-034 MUL x3,x1,x2 (0x022081B3) -> out_illegal=0, alu_op=MUL with DECODE_M_EXT_EN; out_illegal=1 without.
